player_motion_ctrl: RTL and testbench

//   Parametrised per-player position controller for the two-player game.

---
 rtl/player_motion_if.sv | 22 ++
 rtl/player_motion_ctrl.sv | 133 +++++++++++++
 tb/tb_player_motion_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/player_motion_if.sv
// Key/state inputs and sprite position outputs for one player's motion controller.
interface player_motion_if #(
  parameter int W = 7
);
  logic         key_left;
  logic         key_right;
  logic         key_jump;
  logic [2:0]   state;
  logic [W-1:0] loc_x;
  logic [W-1:0] loc_y;
  logic         airborne;

  modport master (
    output key_left, key_right, key_jump, state,
    input  loc_x, loc_y, airborne
  );

  modport slave (
    input  key_left, key_right, key_jump, state,
    output loc_x, loc_y, airborne
  );
endinterface

// File: rtl/player_motion_ctrl.sv
// Per-player tile position controller: tick-rate-limited lane-clamped horizontal
// motion plus a GROUND/RISE/FALL jump machine, reloaded whenever the game leaves GAME.
module player_motion_ctrl #(
  parameter int W        = 7,
  parameter int X_START  = 57,
  parameter int Y_START  = 34,
  parameter int X_MIN    = 35,
  parameter int X_MAX    = 59,
  parameter int MOVE_DIV = 4,
  parameter int JUMP_H   = 6
) (
  input logic            clk,
  input logic            rst,
  player_motion_if.slave bus
);

  localparam int TW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int HW = $clog2(JUMP_H + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(MOVE_DIV - 1);
  localparam logic [HW-1:0] H_TOP     = HW'(JUMP_H);
  localparam logic [W-1:0]  X_INIT    = W'(X_START);
  localparam logic [W-1:0]  Y_GND     = W'(Y_START);
  localparam logic [W-1:0]  X_LO      = W'(X_MIN);
  localparam logic [W-1:0]  X_HI      = W'(X_MAX);

  typedef enum logic [2:0] {
    MENU  = 3'b000,
    GAME  = 3'b001,
    P1WIN = 3'b010,
    P2WIN = 3'b011,
    TIE   = 3'b100,
    POINT = 3'b101
  } game_t;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } jump_t;

  jump_t         js, js_n;
  logic [W-1:0]  loc_x, loc_x_n;
  logic [W-1:0]  loc_y, loc_y_n;
  logic [TW-1:0] tick_cnt, tick_cnt_n;
  logic [HW-1:0] height_cnt, height_cnt_n;
  logic          key_jump_d;
  logic          tick;
  logic          jump_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      js         <= GROUND;
      loc_x      <= X_INIT;
      loc_y      <= Y_GND;
      tick_cnt   <= '0;
      height_cnt <= '0;
      key_jump_d <= 1'b0;
    end else begin
      js         <= js_n;
      loc_x      <= loc_x_n;
      loc_y      <= loc_y_n;
      tick_cnt   <= tick_cnt_n;
      height_cnt <= height_cnt_n;
      key_jump_d <= bus.key_jump;
    end
  end

  always_comb begin
    js_n         = js;
    loc_x_n      = loc_x;
    loc_y_n      = loc_y;
    tick_cnt_n   = tick_cnt;
    height_cnt_n = height_cnt;
    tick         = (tick_cnt == TICK_LAST);
    jump_edge    = bus.key_jump & ~key_jump_d;

    case (game_t'(bus.state))
      GAME: begin
        tick_cnt_n = tick ? '0 : tick_cnt + 1'b1;

        if (tick) begin
          if (bus.key_left && !bus.key_right && (loc_x > X_LO))
            loc_x_n = loc_x - 1'b1;
          else if (bus.key_right && !bus.key_left && (loc_x < X_HI))
            loc_x_n = loc_x + 1'b1;
        end

        // Edges during RISE/FALL are dropped, so a held key cannot retrigger on landing.
        case (js)
          GROUND: begin
            if (jump_edge) begin
              js_n         = RISE;
              height_cnt_n = '0;
            end
          end
          RISE: begin
            if (tick) begin
              loc_y_n      = loc_y - 1'b1;
              height_cnt_n = height_cnt + 1'b1;
              if (height_cnt + 1'b1 == H_TOP)
                js_n = FALL;
            end
          end
          FALL: begin
            if (tick) begin
              loc_y_n = loc_y + 1'b1;
              if (loc_y + 1'b1 == Y_GND)
                js_n = GROUND;
            end
          end
          default: js_n = GROUND;
        endcase
      end

      MENU, P1WIN, P2WIN, TIE, POINT: begin
        js_n         = GROUND;
        loc_x_n      = X_INIT;
        loc_y_n      = Y_GND;
        tick_cnt_n   = '0;
        height_cnt_n = '0;
      end

      // Undefined codes freeze everything except the jump-key history.
      default: ;
    endcase
  end

  assign bus.loc_x    = loc_x;
  assign bus.loc_y    = loc_y;
  assign bus.airborne = (js != GROUND);

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl: stimulus queues expected positions per
// clock edge, a negedge monitor pops and compares them against the DUT outputs.
module tb_player_motion_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  player_motion_if #(.W(7)) bus ();

  player_motion_ctrl #(
    .W(7), .X_START(57), .Y_START(34), .X_MIN(35), .X_MAX(59),
    .MOVE_DIV(4), .JUMP_H(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         cyc;
    logic [6:0] x;
    logic [6:0] y;
    logic       air;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   edges   = 0;
  int   n_check = 0;
  int   n_fail  = 0;

  always @(posedge clk) edges <= edges + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= edges) begin
      exp_t e;
      e = q.pop_front();
      n_check++;
      if (e.cyc != edges) begin
        n_fail++;
        $display("FAIL %s stale expectation: due edge %0d, checked at edge %0d", e.tag, e.cyc, edges);
      end else if (bus.loc_x !== e.x || bus.loc_y !== e.y || bus.airborne !== e.air) begin
        n_fail++;
        $display("FAIL %s edge %0d: got x=%0d y=%0d air=%0b, expected x=%0d y=%0d air=%0b",
                 e.tag, edges, bus.loc_x, bus.loc_y, bus.airborne, e.x, e.y, e.air);
      end
    end
  end

  task automatic expect_now(input int x, input int y, input bit air, input string tag);
    exp_t e;
    e.cyc = edges;
    e.x   = 7'(x);
    e.y   = 7'(y);
    e.air = air;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_exp(input int x, input int y, input bit air, input string tag);
    step();
    expect_now(x, y, air, tag);
  endtask

  // One MENU cycle: reload position and zero the tick divider, then back to GAME.
  task automatic reload();
    bus.state = 3'b000;
    step_exp(57, 34, 1'b0, "reload");
    bus.state = 3'b001;
  endtask

  // Edge k counts GAME edges from the jump-trigger edge (k=1); ticks fall on k=4,8,...
  task automatic jump_expect(input int k, input bit right, input string tag);
    int n, x, y;
    n = k / 4;
    if (n > 12) n = 12;
    y = (n <= 6) ? 34 - n : 22 + n;
    x = right ? ((57 + k / 4 > 59) ? 59 : 57 + k / 4) : 57;
    step_exp(x, y, (k / 4) < 12, tag);
  endtask

  initial begin
    bus.key_left  = 1'b0;
    bus.key_right = 1'b0;
    bus.key_jump  = 1'b0;
    bus.state     = 3'b001;

    // Asynchronous reset asserted between edges must act before the next edge.
    @(posedge clk);
    #2;
    rst = 1'b1;
    expect_now(57, 34, 1'b0, "async_rst");
    step_exp(57, 34, 1'b0, "rst_hold");
    step_exp(57, 34, 1'b0, "rst_hold");
    rst = 1'b0;
    for (int i = 0; i < 40; i++) step_exp(57, 34, 1'b0, "idle_game");

    // Left held: one step per 4 edges, clamped at 35 after 22 ticks.
    reload();
    bus.key_left = 1'b1;
    for (int k = 1; k <= 88; k++) step_exp(57 - k / 4, 34, 1'b0, "move_left");
    for (int k = 0; k < 20; k++) step_exp(35, 34, 1'b0, "clamp_left");
    bus.key_left = 1'b0;

    // Right held: clamp at 59, then both keys hold.
    reload();
    bus.key_right = 1'b1;
    for (int k = 1; k <= 16; k++) step_exp((57 + k / 4 > 59) ? 59 : 57 + k / 4, 34, 1'b0, "move_right");
    bus.key_left = 1'b1;
    for (int k = 0; k < 20; k++) step_exp(59, 34, 1'b0, "both_keys");
    bus.key_left  = 1'b0;
    bus.key_right = 1'b0;

    // Single-cycle jump pulse: full arc of 12 ticks, then ground.
    reload();
    bus.key_jump = 1'b1;
    jump_expect(1, 1'b0, "jump_pulse");
    bus.key_jump = 1'b0;
    for (int k = 2; k <= 56; k++) jump_expect(k, 1'b0, "jump_pulse");

    // Jump key held throughout: exactly one jump.
    reload();
    bus.key_jump = 1'b1;
    for (int k = 1; k <= 64; k++) jump_expect(k, 1'b0, "jump_held");
    bus.key_jump = 1'b0;

    // Mid-jump reload with right held, then first move 4 edges after returning.
    reload();
    bus.key_right = 1'b1;
    bus.key_jump  = 1'b1;
    jump_expect(1, 1'b1, "jump_right");
    bus.key_jump = 1'b0;
    for (int k = 2; k <= 17; k++) jump_expect(k, 1'b1, "jump_right");
    bus.state = 3'b010;
    step_exp(57, 34, 1'b0, "p1win_reload");
    bus.state = 3'b001;
    for (int k = 1; k <= 8; k++) step_exp(57 + k / 4, 34, 1'b0, "after_reload");
    bus.key_right = 1'b0;

    // Undefined state code freezes mid-jump; the arc resumes on the frozen phase.
    reload();
    bus.key_jump = 1'b1;
    jump_expect(1, 1'b0, "freeze_jump");
    bus.key_jump = 1'b0;
    for (int k = 2; k <= 14; k++) jump_expect(k, 1'b0, "freeze_jump");
    bus.state = 3'b110;
    for (int i = 0; i < 10; i++) step_exp(57, 31, 1'b1, "frozen");
    bus.state = 3'b001;
    for (int k = 15; k <= 52; k++) jump_expect(k, 1'b0, "resume_jump");

    step();
    step();
    n_check++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
